// File: rtl/neuai_led_7seg_scan_ctrl_pkg.sv
// Shared types and constants for the 7-seg scan controller.
package neuai_led_7seg_scan_ctrl_pkg;

  typedef enum logic [1:0] {
    S_OFF   = 2'd0,
    S_SHOW  = 2'd1,
    S_BLANK = 2'd2
  } state_t;

  // One register-bank entry: {en, dp, val}
  typedef struct packed {
    logic       en;
    logic       dp;
    logic [3:0] val;
  } digit_t;

  localparam logic [7:0] SEG_OFF   = 8'h00;
  localparam int         WR_EN_BIT = 5;
  localparam int         WR_DP_BIT = 4;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/neuai_led_7seg_scan_ctrl_if.sv
// Host-side bus: scan enable, shadow-bank writes, commit handshake, frame pulse.
interface neuai_led_7seg_scan_ctrl_if;
  logic       scan_en;
  logic       wr_en;
  logic [2:0] wr_addr;
  logic [5:0] wr_data;
  logic       commit;
  logic       busy;
  logic       frame_done;

  modport master (output scan_en, wr_en, wr_addr, wr_data, commit,
                  input  busy, frame_done);
  modport slave  (input  scan_en, wr_en, wr_addr, wr_data, commit,
                  output busy, frame_done);
endinterface

// File: rtl/neuai_hex_to_7seg.sv
// Combinational hex nibble to 7-segment (gfedcba, active-high) decoder.
module neuai_hex_to_7seg (
  input  logic [3:0] hex,
  output logic [6:0] seg
);
  // Lookup of the standard hex glyph set
  always_comb begin
    seg = 7'h00;
    case (hex)
      4'h0: seg = 7'h3F;
      4'h1: seg = 7'h06;
      4'h2: seg = 7'h5B;
      4'h3: seg = 7'h4F;
      4'h4: seg = 7'h66;
      4'h5: seg = 7'h6D;
      4'h6: seg = 7'h7D;
      4'h7: seg = 7'h07;
      4'h8: seg = 7'h7F;
      4'h9: seg = 7'h6F;
      4'hA: seg = 7'h77;
      4'hB: seg = 7'h7C;
      4'hC: seg = 7'h39;
      4'hD: seg = 7'h5E;
      4'hE: seg = 7'h79;
      4'hF: seg = 7'h71;
      default: seg = 7'h00;
    endcase
  end
endmodule

// File: rtl/neuai_led_7seg_scan_ctrl.sv
// Time-multiplexed N-digit 7-seg scan controller with shadow/active banks
// that swap only at a frame boundary, plus a blanking gap between digits.
module neuai_led_7seg_scan_ctrl
  import neuai_led_7seg_scan_ctrl_pkg::*;
#(
  parameter int DIGITS     = 4,
  parameter int SCAN_DIV   = 50000,
  parameter int BLANK_CYC  = 500,
  parameter bit DIG_ACT_LO = 1'b1
) (
  input  logic                        clk,
  input  logic                        rst,
  neuai_led_7seg_scan_ctrl_if.slave   bus,
  output logic [7:0]                  led_7seg,
  output logic [DIGITS-1:0]           dig_out
);

  localparam int CW = (max2(SCAN_DIV, BLANK_CYC) > 2) ? $clog2(max2(SCAN_DIV, BLANK_CYC)) : 1;
  localparam int IW = $clog2(DIGITS);
  localparam logic [DIGITS-1:0] DIG_OFF = {DIGITS{DIG_ACT_LO}};

  state_t            state, nstate;
  logic [IW-1:0]     idx, nidx;
  logic [CW-1:0]     cnt, ncnt;
  logic              wrap;
  digit_t            shadow [DIGITS];
  digit_t            active [DIGITS];
  digit_t            wd, cur;
  logic              busy_q, fd_q, copy;
  logic [6:0]        hex_seg;
  logic [DIGITS-1:0] sel;

  assign wd = '{en: bus.wr_data[WR_EN_BIT], dp: bus.wr_data[WR_DP_BIT], val: bus.wr_data[3:0]};

  // Copy fires on the frame_done cycle, or immediately while the scan is off.
  // The outputs sample the shadow value on that edge so the new frame's first
  // digit already shows the committed data.
  assign copy = (busy_q | bus.commit) & (fd_q | (state == S_OFF));
  assign cur  = copy ? shadow[idx] : active[idx];
  assign sel  = {{(DIGITS-1){1'b0}}, 1'b1} << idx;

  assign bus.busy       = busy_q;
  assign bus.frame_done = fd_q;

  neuai_hex_to_7seg u_hex (.hex(cur.val), .seg(hex_seg));

  // Scan FSM state, digit index and dwell counter
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= S_OFF;
      idx   <= '0;
      cnt   <= '0;
    end else begin
      state <= nstate;
      idx   <= nidx;
      cnt   <= ncnt;
    end
  end

  // Next-state: show for SCAN_DIV, blank for BLANK_CYC, advance/wrap index
  always_comb begin
    nstate = state;
    nidx   = idx;
    ncnt   = cnt;
    wrap   = 1'b0;
    if (!bus.scan_en) begin
      nstate = S_OFF;
      nidx   = '0;
      ncnt   = '0;
    end else begin
      case (state)
        S_OFF: begin
          nstate = S_SHOW;
          nidx   = '0;
          ncnt   = '0;
        end
        S_SHOW: begin
          if (cnt == CW'(SCAN_DIV - 1)) begin
            nstate = S_BLANK;
            ncnt   = '0;
          end else begin
            ncnt = cnt + 1'b1;
          end
        end
        S_BLANK: begin
          if (cnt == CW'(BLANK_CYC - 1)) begin
            nstate = S_SHOW;
            ncnt   = '0;
            if (idx == IW'(DIGITS - 1)) begin
              nidx = '0;
              wrap = 1'b1;
            end else begin
              nidx = idx + 1'b1;
            end
          end else begin
            ncnt = cnt + 1'b1;
          end
        end
        default: begin
          nstate = S_OFF;
          nidx   = '0;
          ncnt   = '0;
        end
      endcase
    end
  end

  // Register banks, commit tracking and frame pulse
  always_ff @(posedge clk) begin
    if (!rst) begin
      busy_q <= 1'b0;
      fd_q   <= 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
    end else begin
      fd_q   <= wrap;
      busy_q <= (busy_q | bus.commit) & ~copy;
      if (copy)
        for (int i = 0; i < DIGITS; i++) active[i] <= shadow[i];
      if (bus.wr_en && ({1'b0, bus.wr_addr} < 4'(DIGITS)))
        shadow[bus.wr_addr[IW-1:0]] <= wd;
    end
  end

  // Registered pin drivers; scan_en low blanks on the very next cycle
  always_ff @(posedge clk) begin
    if (!rst) begin
      led_7seg <= SEG_OFF;
      dig_out  <= DIG_OFF;
    end else if (bus.scan_en && state == S_SHOW) begin
      led_7seg <= cur.en ? {cur.dp, hex_seg} : SEG_OFF;
      dig_out  <= DIG_ACT_LO ? ~sel : sel;
    end else begin
      led_7seg <= SEG_OFF;
      dig_out  <= DIG_OFF;
    end
  end

endmodule

// File: tb/tb_neuai_led_7seg_scan_ctrl.sv
// Directed scoreboard bench for the 7-seg scan controller.
module tb_neuai_led_7seg_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] led_7seg;
  logic [3:0] dig_out;

  neuai_led_7seg_scan_ctrl_if bus();

  neuai_led_7seg_scan_ctrl #(
    .DIGITS(4), .SCAN_DIV(4), .BLANK_CYC(1), .DIG_ACT_LO(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus), .led_7seg(led_7seg), .dig_out(dig_out)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] led;
    logic [3:0] dig;
    logic       fd;
    logic       busy;
  } exp_t;

  exp_t       sbq [$];
  int         tests = 0;
  int         fails = 0;
  logic [5:0] m_sh  [4];
  logic [5:0] m_act [4];
  logic [6:0] hex_tab [16];

  function automatic logic [7:0] seg_of(input logic [5:0] d);
    return d[5] ? {d[4], hex_tab[d[3:0]]} : 8'h00;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected 20-cycle frame starting at the frame_done (blank) cycle
  task automatic push_frame(input logic fd0, input logic busy0);
    sbq.push_back(exp_t'{8'h00, 4'hF, fd0, busy0});
    for (int d = 0; d < 4; d++) begin
      for (int k = 0; k < 4; k++)
        sbq.push_back(exp_t'{seg_of(m_act[d]), ~(4'b0001 << d), 1'b0, 1'b0});
      if (d < 3) sbq.push_back(exp_t'{8'h00, 4'hF, 1'b0, 1'b0});
    end
  endtask

  task automatic sb_check(input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      if (i > 0) @(negedge clk);
      if (sbq.size() == 0) begin
        tests++;
        fails++;
        $error("FAIL sb_empty observed=0 expected=entry");
      end else begin
        e = sbq.pop_front();
        chk($sformatf("led[%0d]", i), led_7seg, e.led);
        chk($sformatf("dig[%0d]", i), dig_out, e.dig);
        chk($sformatf("fd[%0d]", i), bus.frame_done, e.fd);
        chk($sformatf("busy[%0d]", i), bus.busy, e.busy);
      end
    end
  endtask

  task automatic wait_fd();
    int n = 0;
    while (bus.frame_done !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("fd_wait", bus.frame_done, 1);
  endtask

  task automatic wr(input int a, input logic [5:0] d);
    bus.wr_en   = 1'b1;
    bus.wr_addr = 3'(a);
    bus.wr_data = d;
    if (a < 4) m_sh[a] = d;
    @(negedge clk);
    bus.wr_en = 1'b0;
  endtask

  task automatic commit_pulse();
    bus.commit = 1'b1;
    @(negedge clk);
    bus.commit = 1'b0;
    chk("busy_set", bus.busy, 1);
  endtask

  task automatic apply_copy();
    for (int i = 0; i < 4; i++) m_act[i] = m_sh[i];
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    hex_tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    for (int i = 0; i < 4; i++) begin
      m_sh[i]  = '0;
      m_act[i] = '0;
    end
    rst = 1'b0;
    bus.scan_en = 1'b0;
    bus.wr_en   = 1'b0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    bus.commit  = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_led", led_7seg, 8'h00);
    chk("rst_dig", dig_out, 4'hF);
    chk("rst_busy", bus.busy, 0);
    chk("rst_fd", bus.frame_done, 0);

    // Reset mid-scan, then restart at digit 0
    rst = 1'b1;
    bus.scan_en = 1'b1;
    repeat (7) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_led", led_7seg, 8'h00);
    chk("midrst_dig", dig_out, 4'hF);
    chk("midrst_busy", bus.busy, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("restart_off", dig_out, 4'hF);
    @(negedge clk);
    chk("restart_d0", dig_out, 4'hE);

    // Load digits, commit, frame shows new data after the boundary
    wait_fd();
    wr(0, 6'h22);
    wr(1, 6'h35);
    wr(2, 6'h2A);
    wr(3, 6'h00);
    commit_pulse();
    wait_fd();
    apply_copy();
    push_frame(1'b1, 1'b1);
    sb_check(20);

    // Cadence: back-to-back frame, frame_done period 20
    @(negedge clk);
    push_frame(1'b1, 1'b0);
    sb_check(20);

    // Commit coincident with frame_done copies at that boundary
    wr(3, 6'h3F);
    bus.commit = 1'b1;
    apply_copy();
    push_frame(1'b1, 1'b0);
    sb_check(1);
    @(negedge clk);
    bus.commit = 1'b0;
    sb_check(19);

    // Out-of-range write is dropped
    @(negedge clk);
    wr(5, 6'h28);
    commit_pulse();
    wait_fd();
    apply_copy();
    push_frame(1'b1, 1'b1);
    sb_check(20);

    // scan_en drop during digit 2, re-enable restarts at digit 0
    @(negedge clk);
    repeat (11) @(negedge clk);
    chk("d2_show", dig_out, 4'hB);
    bus.scan_en = 1'b0;
    @(negedge clk);
    chk("off_led", led_7seg, 8'h00);
    chk("off_dig", dig_out, 4'hF);
    chk("off_fd", bus.frame_done, 0);
    repeat (2) @(negedge clk);
    chk("off_hold_dig", dig_out, 4'hF);
    bus.scan_en = 1'b1;
    @(negedge clk);
    push_frame(1'b0, 1'b0);
    sb_check(20);
    @(negedge clk);
    chk("fd_after_restart", bus.frame_done, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
